// File: rtl/seq_detect_mealy_if.sv
// Serial-bit stream in, match flags and match count out, for seq_detect_mealy.
// master drives the bit stream; slave is the detector.
interface seq_detect_mealy_if #(
  parameter int CNT_W = 8
);
  logic             inp;
  logic             in_valid;
  logic             out;
  logic             match_q;
  logic [CNT_W-1:0] match_count;

  modport master (
    output inp,
    output in_valid,
    input  out,
    input  match_q,
    input  match_count
  );

  modport slave (
    input  inp,
    input  in_valid,
    output out,
    output match_q,
    output match_count
  );
endinterface

// File: rtl/seq_detect_mealy.sv
// Mealy detector for a programmable PAT_LEN-bit pattern; SEQDET_COUNT_EN adds a saturating match counter.
// Latency: out is combinational in the completing cycle, match_q follows one cycle later.
// No backpressure: a bit is consumed at every rising edge where in_valid=1.
module seq_detect_mealy #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_mealy_if.slave bus
);

  localparam int SW    = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam int TBL_W = 2 * PAT_LEN * SW;

  // Bit i of the pattern in arrival order (i=0 is received first).
  function automatic logic pat_bit(input int i);
    logic [PAT_LEN-1:0] sh;
    sh = PATTERN >> (PAT_LEN - 1 - i);
    return sh[0];
  endfunction

  // Entry (2*k+b) holds the longest proper pattern prefix that is a suffix of
  // (prefix of length k) followed by bit b. For the completing bit this is the
  // longest proper border, which is exactly the overlapping restart state.
  function automatic logic [TBL_W-1:0] build_table();
    logic [TBL_W-1:0] tbl;
    int               best;
    int               si;
    logic             ok;
    logic             sb;
    tbl = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int j = 1; (j <= k + 1) && (j < PAT_LEN); j++) begin
          ok = 1'b1;
          for (int t = 0; t < j; t++) begin
            si = k + 1 - j + t;
            sb = (si == k) ? b[0] : pat_bit(si);
            if (sb != pat_bit(t)) ok = 1'b0;
          end
          if (ok) best = j;
        end
        tbl = tbl | (TBL_W'(best) << ((2 * k + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NXT_TBL = build_table();

  logic [SW-1:0]    state;
  logic [SW-1:0]    nxt;
  logic [TBL_W-1:0] tbl_sh;
  logic             hit;
  logic             match_r;

  assign tbl_sh = NXT_TBL >> (SW * int'({state, bus.inp}));
  assign nxt    = tbl_sh[SW-1:0];

  // Reset gates the flag so bits seen before reset can never complete a match.
  assign hit = rst && bus.in_valid && (state == SW'(PAT_LEN - 1)) && (bus.inp == PATTERN[0]);

  assign bus.out     = hit;
  assign bus.match_q = match_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= '0;
      match_r <= 1'b0;
    end else begin
      match_r <= hit;
      if (bus.in_valid) begin
        state <= (hit && !OVERLAP) ? '0 : nxt;
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] count_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= '0;
    end else if (hit && (count_r != '1)) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign bus.match_count = count_r;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy: default pattern with and without overlap,
// a 2-bit-counter instance for saturation, and a "11" instance for back-to-back matches.
module tb_seq_detect_mealy;

`ifdef SEQDET_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inp = 1'b0;
  logic in_valid = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_mealy_if #(.CNT_W(8)) if_ov  ();
  seq_detect_mealy_if #(.CNT_W(8)) if_no  ();
  seq_detect_mealy_if #(.CNT_W(2)) if_sat ();
  seq_detect_mealy_if #(.CNT_W(8)) if_p11 ();

  assign if_ov.inp       = inp;
  assign if_ov.in_valid  = in_valid;
  assign if_no.inp       = inp;
  assign if_no.in_valid  = in_valid;
  assign if_sat.inp      = inp;
  assign if_sat.in_valid = in_valid;
  assign if_p11.inp      = inp;
  assign if_p11.in_valid = in_valid;

  seq_detect_mealy #(.OVERLAP(1'b1)) u_ov (.clk(clk), .rst(rst), .bus(if_ov.slave));
  seq_detect_mealy #(.OVERLAP(1'b0)) u_no (.clk(clk), .rst(rst), .bus(if_no.slave));
  seq_detect_mealy #(.OVERLAP(1'b0), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if_sat.slave));
  seq_detect_mealy #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) u_p11 (.clk(clk), .rst(rst), .bus(if_p11.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input at the falling edge; the Mealy output is then settled.
  task automatic feed(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    inp      = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    inp      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq4;
    logic [6:0] seq7;
    int         exp_sat;
    seq4 = 4'b1011;
    seq7 = 7'b1011011;

    // Reset held two cycles with valid toggling data.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inp = (i == 0);
      #1;
      chk("rst_out_ov", if_ov.out, 0);
      chk("rst_out_p11", if_p11.out, 0);
      tick();
      chk("rst_match_q", if_ov.match_q, 0);
      chk("rst_count", if_ov.match_count, 0);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;

    // Basic single match.
    do_rst();
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, seq4[2'(3 - i)]);
      chk("basic_out", if_ov.out, (i == 3));
      tick();
      chk("basic_match_q", if_ov.match_q, (i == 3));
    end
    chk("basic_count", if_ov.match_count, CE);
    feed(1'b0, 1'b1);
    chk("basic_idle_out", if_ov.out, 0);
    tick();
    chk("basic_match_q_drop", if_ov.match_q, 0);

    // Overlapping versus restarting after a match.
    do_rst();
    for (int i = 0; i < 7; i++) begin
      feed(1'b1, seq7[3'(6 - i)]);
      chk("ovl_out", if_ov.out, (i == 3) || (i == 6));
      chk("novl_out", if_no.out, (i == 3));
      chk("p11_mixed_out", if_p11.out, (i == 3) || (i == 6));
      tick();
    end
    chk("ovl_count", if_ov.match_count, 2 * CE);
    chk("novl_count", if_no.match_count, CE);

    // Gaps in in_valid must not consume the (matching) data bit.
    do_rst();
    feed(1'b1, 1'b1);
    chk("gap_out_b1", if_ov.out, 0);
    feed(1'b1, 1'b0);
    chk("gap_out_b2", if_ov.out, 0);
    for (int i = 0; i < 3; i++) begin
      feed(1'b0, 1'b1);
      chk("gap_out_idle", if_ov.out, 0);
    end
    feed(1'b1, 1'b1);
    chk("gap_out_b3", if_ov.out, 0);
    feed(1'b1, 1'b1);
    chk("gap_out_b4", if_ov.out, 1);
    tick();
    chk("gap_count", if_ov.match_count, CE);

    // Reset in the middle of a partial match.
    do_rst();
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b1);
    chk("mid_pre_out", if_ov.out, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    inp      = 1'b1;
    #1;
    chk("mid_rst_out", if_ov.out, 0);
    tick();
    chk("mid_rst_match_q", if_ov.match_q, 0);
    chk("mid_rst_count", if_ov.match_count, 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    feed(1'b1, 1'b1);
    chk("mid_after_out", if_ov.out, 0);
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, seq4[2'(3 - i)]);
      chk("mid_full_out", if_ov.out, (i == 3));
    end
    tick();
    chk("mid_full_count", if_ov.match_count, CE);

    // Saturating 2-bit counter over five separate matches.
    do_rst();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        feed(1'b1, seq4[2'(3 - i)]);
        tick();
      end
      exp_sat = (r + 1 > 3) ? 3 : r + 1;
      chk("sat_count", if_sat.match_count, exp_sat * CE);
      chk("wide_count", if_no.match_count, (r + 1) * CE);
    end

    // Pattern 11 with overlap: a match on every valid 1 after the first.
    do_rst();
    for (int i = 0; i < 5; i++) begin
      feed(1'b1, 1'b1);
      chk("b2b_out", if_p11.out, (i > 0));
      tick();
      chk("b2b_match_q", if_p11.match_q, (i > 0));
    end
    chk("b2b_count", if_p11.match_count, 4 * CE);

    feed(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised Mealy sequence detector: the configurable successor to the team's fixed single-pattern Mealy FSM. It scans a serial bit stream qualified by a valid strobe and flags, in the same cycle, every input bit that completes a programmable pattern. Overlapping or non-overlapping matching is selectable, and an optional saturating match counter can be compiled in. It sits between a serial front-end and control logic that consumes single-cycle match pulses.

## Interface
- PAT_LEN, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1011: pattern, PAT_LEN bits wide; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1: 1 means a match may share bits with the next match; 0 means the detector restarts from empty after a match.
- CNT_W, 8: width of match_count.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- inp  input  1  serial data bit.
- in_valid  input  1  inp is consumed only in cycles where in_valid=1.
- out  output  1  Mealy match flag, combinational from state, inp, in_valid and rst.
- match_q  output  1  out registered; one-cycle-delayed copy.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- The state is the length k (0..PAT_LEN-1) of the longest pattern prefix that is a suffix of the consumed bits.
- Next-state function: KMP-style fallback, computed at elaboration from PATTERN. No hand-coded tables.
- Match condition: in_valid=1, k=PAT_LEN-1, and inp equals the last pattern bit (PATTERN[0]). When it holds, out=1.
- State after a match:
  - OVERLAP=1: the length of the longest proper border of PATTERN.
  - OVERLAP=0: 0.
- State on a mismatch: the longest prefix that is a suffix of (matched prefix followed by inp). This can be nonzero.
- Default pattern 1011, transitions written as k:bit→k':
  - 0:1→1, 0:0→0
  - 1:0→2, 1:1→1
  - 2:1→3, 2:0→0
  - 3:0→2
  - 3:1→match, then 1 if OVERLAP=1, or 0 if OVERLAP=0.
- in_valid=0: state holds, out=0, and the counter holds. inp is don't-care.
- rst=0 at a rising edge: state←0, match_q←0, match_count←0. While rst=0, out is forced to 0 combinationally.
- Reset during a partial match discards the prefix. No match can complete using bits consumed before reset.
- A rising edge with rst=1, in_valid=1 and a match increments match_count.

## Timing
- out has zero latency: it is valid in the cycle the completing bit is presented. It is only meaningful at the rising edge.
- match_q is asserted in the cycle after out was 1 at a rising edge, for exactly one cycle per match.
- match_count updates at the same edge that samples out=1.
- Reset values: out=0, match_q=0, match_count=0. State is 0 at the first edge after rst is released.
- Back-to-back matches are possible. Example: pattern 11, OVERLAP=1, continuous 1s give out=1 on every valid cycle after the first.
- There is no combinational path from out to any input. inp and in_valid must be stable around the rising edge.

## Configuration
- SEQDET_COUNT_EN defined: match_count is a CNT_W-bit saturating counter. It increments on each match and holds at 2^CNT_W−1.
- SEQDET_COUNT_EN undefined: no counter logic; match_count is tied to 0. Port list unchanged.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1 and inp toggling → out=0, match_q=0, match_count=0 throughout.
- Basic match (defaults, count enabled): valid bits 1,0,1,1 → out=1 only during the 4th bit; match_q=1 the next cycle; match_count=1.
- Overlap: valid bits 1,0,1,1,0,1,1.
  - OVERLAP=1: out=1 on bits 4 and 7; match_count=2.
  - OVERLAP=0: out=1 on bit 4 only; match_count=1.
- Valid gaps: bits 1,0, then 3 cycles of in_valid=0 with inp=1, then valid bits 1,1 → out=0 during the gaps; out=1 on the final valid 1; match_count=1.
- Mid-sequence reset: valid 1,0,1, then rst=0 for one cycle, then valid 1 → no match. A subsequent full 1,0,1,1 → out=1.
- Saturation: CNT_W=2, SEQDET_COUNT_EN defined, 5 non-overlapping 1011 sequences → match_count = 1,2,3,3,3. With the macro undefined → match_count stays 0.
